hall_rpm_calculator: RTL and testbench
======================================

// Module: hall_rpm_calculator
// PURPOSE
// - Downstream consumer of the Hall edge-interval detector; all logic in the clock_3 domain.
// - Takes the detector's high/low interval counts plus raw Hall signal SA (used for period framing).
// - Forms one period sample per SA rising edge, rejects glitches, keeps a moving average,
//   converts it to RPM with a sequential divider, and flags a stalled motor.
// - rpm output feeds the closed-loop speed controller.
// PARAMETERS
// - CLK_FREQ_HZ     100_000_000  clock_3 frequency; RPM_SCALE = CLK_FREQ_HZ*60
// - PULSES_PER_REV  1            SA rising edges per mechanical revolution (>=1)
// - AVG_LOG2        2            moving-average depth = 2**AVG_LOG2 samples (0..4)
// - MIN_PERIOD      1_000        samples below this count are discarded as glitches
// - STALL_CYCLES    50_000_000   cycles with no SA rising edge before stall is declared
// - RPM_W           16           rpm output width
// PORTS
// - clock_3       in   1      system clock, 100 MHz
// - Reset         in   1      asynchronous, active-low reset
// - SA            in   1      raw Hall signal (asynchronous)
// - high_counter  in   32     detector high-interval count
// - low_counter   in   32     detector low-interval count
// - rpm           out  RPM_W  averaged speed, saturated
// - rpm_valid     out  1      one-cycle strobe when rpm updates
// - period_avg    out  32     averaged period in clock_3 cycles
// - stalled       out  1      level: no SA rising edge for STALL_CYCLES
// BEHAVIOUR
// - Reset (Reset=0, async): rpm=0, rpm_valid=0, period_avg=0, stalled=0.
//   Reset also clears the ring buffer, sum, fill count and stall counter, and puts the FSM in IDLE.
//   Reset mid-division aborts it; no rpm_valid follows.
// - SA input: 2-flop synchroniser, then rising-edge detect.
//   sample_en fires 1 cycle after the detected edge, so the detector has already updated.
// - Sample: period = high_counter + low_counter + 2, computed in 33 bits, saturated to 32'hFFFF_FFFF.
//   If period < MIN_PERIOD: discard (no buffer write, stall counter still cleared).
// - Averaging: 2**AVG_LOG2-entry ring buffer with running sum (32+AVG_LOG2 bits).
//   On write: sum += new - oldest; write pointer wraps modulo depth.
//   period_avg = sum >> AVG_LOG2, but only once fill count reaches depth.
//   Before the buffer is full: no division starts and rpm holds its value.
// - FSM: IDLE -> LOAD -> DIV -> DONE -> IDLE.
//   IDLE->LOAD when the buffer is full and a fresh average is pending.
//   LOAD: latch dividend = RPM_SCALE (40 bits) and divisor = period_avg*PULSES_PER_REV (40 bits).
//   DIV: 40 restoring iterations, one bit per cycle.
//   DONE: rpm = min(quotient, 2**RPM_W-1); rpm_valid = 1 for one cycle.
//   Fixed latency: sample_en to rpm_valid = 43 cycles.
// - Samples arriving while not IDLE still update the buffer and set pending.
//   The next division uses the latest average; no queueing of multiple results.
// - Divisor 0: cannot occur (period >= 2); guard anyway, giving rpm = max.
// - Stall: counter increments each cycle and is cleared on every SA rising edge. It saturates.
//   At count == STALL_CYCLES: stalled = 1, rpm = 0, one rpm_valid pulse, buffer and fill count cleared.
//   Any division in progress is aborted.
//   stalled clears on the next rising edge; rpm stays 0 until the buffer refills.
// - Simultaneous stall threshold and sample_en: the sample wins and the stall counter clears.
// STRUCTURE
// - Shared package hall_pkg:
//   - RPM_SCALE and the divider width DIV_W = 40
//   - FSM state enum {IDLE, LOAD, DIV, DONE}
//   - saturation helper function
// - Sub-module seq_divider (DIV_W param): start/busy/done handshake, unsigned restoring divide,
//   async active-low reset. Divide by zero returns all ones.
// - Top level: synchroniser/edge detect, ring buffer + sum, stall counter, FSM, output registers.
// TESTING
// - SA 50k high / 50k low cycles, 8 periods (PPR=1, depth 4):
//   period_avg = 100000, rpm = 60000; first rpm_valid follows the 4th sample by 43 cycles.
// - SA period 1_000_000 cycles -> rpm = 6000; then step to period 2_000_000.
//   rpm averages through the step and settles at 3000 after 4 samples.
// - SA period 50_000 -> quotient 120000 -> rpm saturates at 65535.
// - SA held low for 50_000_000 cycles -> stalled = 1, rpm = 0, one rpm_valid.
//   Next rising edge clears stalled; rpm_valid is silent until 4 new samples arrive.
// - Period 200 inserted into a steady 100000 stream -> sample discarded, rpm remains 60000.
// - Assert Reset during DIV -> all outputs 0 immediately, no rpm_valid.
//   After release, recovery needs 4 new samples.

Source files
------------

// File: rtl/hall_pkg.sv
// Shared types and helpers for the Hall speed path: divider width, FSM states,
// RPM scale and saturation helpers.
package hall_pkg;

  localparam int DIV_W = 40;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_e;

  // Clock cycles per minute: the dividend that turns a period into RPM.
  function automatic logic [DIV_W-1:0] rpm_scale(input int unsigned clk_hz);
    return DIV_W'(clk_hz) * DIV_W'(60);
  endfunction

  function automatic logic [31:0] sat_u32(input logic [32:0] v);
    return v[32] ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  function automatic logic [DIV_W-1:0] sat_width(input logic [DIV_W-1:0] v,
                                                 input int unsigned w);
    logic [DIV_W-1:0] lim;
    lim = (DIV_W'(1) << w) - DIV_W'(1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses on the last
// iteration with the final quotient. Divide by zero yields all ones.
module seq_divider #(
  parameter int DIV_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int CW = $clog2(DIV_W);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;

  logic [DIV_W:0]   rem_sh;
  logic [DIV_W:0]   rem_diff;
  logic             fits;
  logic [DIV_W-1:0] quo_nx;
  logic             last_iter;

  assign rem_sh    = {rem_q, quo_q[DIV_W-1]};
  assign rem_diff  = rem_sh - {1'b0, dvs_q};
  assign fits      = (rem_sh >= {1'b0, dvs_q});
  assign quo_nx    = {quo_q[DIV_W-2:0], fits};
  assign last_iter = (cnt_q == CW'(DIV_W - 1));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
    end else if (busy_q) begin
      rem_d = fits ? rem_diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
      quo_d = quo_nx;
      cnt_d = cnt_q + CW'(1);
      if (last_iter) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && !abort && last_iter;
  assign quotient = (dvs_q == '0) ? '1 : quo_nx;

endmodule

// File: rtl/hall_rpm_calculator.sv
// Hall period averaging and RPM conversion with stall detection.
// Latency: sample_en to rpm_valid is 43 cycles (SA edge to rpm_valid is 46).
module hall_rpm_calculator
  import hall_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned PULSES_PER_REV = 1,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned MIN_PERIOD     = 1_000,
  parameter int unsigned STALL_CYCLES   = 50_000_000,
  parameter int unsigned RPM_W          = 16
) (
  input  logic             clock_3,
  input  logic             Reset,
  input  logic             SA,
  input  logic [31:0]      high_counter,
  input  logic [31:0]      low_counter,
  output logic [RPM_W-1:0] rpm,
  output logic             rpm_valid,
  output logic [31:0]      period_avg,
  output logic             stalled
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int SW    = 32 + AVG_LOG2;
  localparam logic [DIV_W-1:0] RPM_SCALE = rpm_scale(CLK_FREQ_HZ);

  logic [2:0]       sa_sync_q, sa_sync_d;
  logic             sample_en_q, sample_en_d;
  logic [31:0]      ring_q [DEPTH];
  logic [31:0]      ring_d [DEPTH];
  logic [SW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             pending_q, pending_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             stalled_q, stalled_d;
  logic [31:0]      period_avg_q, period_avg_d;
  logic [RPM_W-1:0] rpm_q, rpm_d;
  logic             rpm_valid_q, rpm_valid_d;
  state_e           state_q, state_d;

  logic             sa_rise;
  logic [31:0]      period;
  logic             sample_ok;
  logic             full;
  logic             stall_hit;
  logic             div_start, div_abort, div_busy, div_done;
  logic [DIV_W-1:0] div_divisor, div_quot;

  // sa_sync_q[1:0] is the synchroniser, sa_sync_q[2] the edge-detect history.
  assign sa_sync_d   = {sa_sync_q[1:0], SA};
  assign sa_rise     = sa_sync_q[1] & ~sa_sync_q[2];
  assign sample_en_d = sa_rise;

  assign period      = sat_u32({1'b0, high_counter} + {1'b0, low_counter} + 33'd2);
  assign sample_ok   = (period >= 32'(MIN_PERIOD));
  assign full        = (fill_q == FW'(DEPTH));
  assign stall_hit   = !sample_en_q && (stall_cnt_q == 32'(STALL_CYCLES - 1));
  assign div_divisor = DIV_W'(period_avg_q) * DIV_W'(PULSES_PER_REV);

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    ring_d       = ring_q;
    sum_d        = sum_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    period_avg_d = period_avg_q;
    rpm_d        = rpm_q;
    rpm_valid_d  = 1'b0;
    stalled_d    = stalled_q;
    stall_cnt_d  = stall_cnt_q;
    div_start    = 1'b0;
    div_abort    = 1'b0;

    if (stall_cnt_q != 32'(STALL_CYCLES)) stall_cnt_d = stall_cnt_q + 32'd1;

    case (state_q)
      IDLE: if (full && pending_q && !div_busy) begin
        state_d   = LOAD;
        pending_d = 1'b0;
      end
      LOAD: begin
        div_start = 1'b1;
        state_d   = DIV;
      end
      DIV: if (div_done) begin
        rpm_d       = RPM_W'(sat_width(div_quot, RPM_W));
        rpm_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A sample in the threshold cycle wins, so stall_hit already excludes it.
    if (sample_en_q) begin
      stall_cnt_d = '0;
      stalled_d   = 1'b0;
      if (sample_ok) begin
        ring_d[ptr_q] = period;
        sum_d         = sum_q + SW'(period) - SW'(ring_q[ptr_q]);
        ptr_d         = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        if (!full) fill_d = fill_q + FW'(1);
        if (fill_d == FW'(DEPTH)) period_avg_d = 32'(sum_d >> AVG_LOG2);
        pending_d = 1'b1;
      end
    end else if (stall_hit) begin
      stall_cnt_d = 32'(STALL_CYCLES);
      stalled_d   = 1'b1;
      rpm_d       = '0;
      rpm_valid_d = 1'b1;
      ring_d      = '{default: '0};
      sum_d       = '0;
      ptr_d       = '0;
      fill_d      = '0;
      pending_d   = 1'b0;
      state_d     = IDLE;
      div_start   = 1'b0;
      div_abort   = 1'b1;
    end
  end

  always_ff @(posedge clock_3 or negedge Reset) begin
    if (!Reset) begin
      sa_sync_q    <= '0;
      sample_en_q  <= 1'b0;
      ring_q       <= '{default: '0};
      sum_q        <= '0;
      ptr_q        <= '0;
      fill_q       <= '0;
      pending_q    <= 1'b0;
      stall_cnt_q  <= '0;
      stalled_q    <= 1'b0;
      period_avg_q <= '0;
      rpm_q        <= '0;
      rpm_valid_q  <= 1'b0;
      state_q      <= IDLE;
    end else begin
      sa_sync_q    <= sa_sync_d;
      sample_en_q  <= sample_en_d;
      ring_q       <= ring_d;
      sum_q        <= sum_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      pending_q    <= pending_d;
      stall_cnt_q  <= stall_cnt_d;
      stalled_q    <= stalled_d;
      period_avg_q <= period_avg_d;
      rpm_q        <= rpm_d;
      rpm_valid_q  <= rpm_valid_d;
      state_q      <= state_d;
    end
  end

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (clock_3),
    .rst_n    (Reset),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (RPM_SCALE),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign rpm        = rpm_q;
  assign rpm_valid  = rpm_valid_q;
  assign period_avg = period_avg_q;
  assign stalled    = stalled_q;

endmodule

// File: tb/tb_hall_rpm_calculator.sv
// Directed bench for hall_rpm_calculator; stall threshold shortened so the run stays short.
module tb_hall_rpm_calculator;

  localparam int unsigned STALL_T = 3000;
  // 3 synchroniser/edge cycles plus the 43-cycle sample_en to rpm_valid path.
  localparam int SA_TO_VALID = 46;

  logic        clock_3 = 1'b0;
  logic        Reset;
  logic        SA;
  logic [31:0] high_counter;
  logic [31:0] low_counter;
  logic [15:0] rpm;
  logic        rpm_valid;
  logic [31:0] period_avg;
  logic        stalled;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  hall_rpm_calculator #(
    .CLK_FREQ_HZ    (100_000_000),
    .PULSES_PER_REV (1),
    .AVG_LOG2       (2),
    .MIN_PERIOD     (1_000),
    .STALL_CYCLES   (STALL_T),
    .RPM_W          (16)
  ) dut (
    .clock_3      (clock_3),
    .Reset        (Reset),
    .SA           (SA),
    .high_counter (high_counter),
    .low_counter  (low_counter),
    .rpm          (rpm),
    .rpm_valid    (rpm_valid),
    .period_avg   (period_avg),
    .stalled      (stalled)
  );

  always #5 clock_3 = ~clock_3;

  always @(negedge clock_3) if (rpm_valid === 1'b1) valid_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock_3);
    #1;
  endtask

  // One SA period framing a sample whose interval sum is hc+lc+2.
  task automatic pulse(input logic [31:0] hc, input logic [31:0] lc);
    high_counter = hc;
    low_counter  = lc;
    SA = 1'b1;
    cyc(10);
    SA = 1'b0;
    cyc(50);
  endtask

  int lat;
  int n;
  int v0;
  int step_rpm [8] = '{18461, 10909, 7741, 6000, 4800, 4000, 3428, 3000};

  initial begin
    Reset = 1'b0;
    SA = 1'b0;
    high_counter = '0;
    low_counter = '0;
    cyc(3);
    check("reset_rpm", rpm, 0);
    check("reset_valid", rpm_valid, 0);
    check("reset_avg", period_avg, 0);
    check("reset_stalled", stalled, 0);
    Reset = 1'b1;
    cyc(5);

    repeat (3) pulse(49_999, 49_999);
    check("no_valid_before_full", valid_cnt, 0);
    check("avg_before_full", period_avg, 0);

    high_counter = 49_999;
    low_counter  = 49_999;
    SA = 1'b1;
    lat = 0;
    while (rpm_valid !== 1'b1 && lat < 200) begin
      cyc(1);
      lat++;
    end
    check("first_latency", lat, SA_TO_VALID);
    check("first_rpm", rpm, 60_000);
    cyc(5);
    SA = 1'b0;
    cyc(50);
    check("first_avg", period_avg, 100_000);

    repeat (4) pulse(49_999, 49_999);
    check("steady_valid_cnt", valid_cnt, 5);
    check("steady_rpm", rpm, 60_000);

    pulse(99, 99);
    check("glitch_valid_cnt", valid_cnt, 5);
    check("glitch_rpm", rpm, 60_000);
    check("glitch_avg", period_avg, 100_000);

    for (int i = 0; i < 8; i++) begin
      if (i < 4) pulse(499_999, 499_999);
      else       pulse(999_999, 999_999);
      check($sformatf("step_rpm_%0d", i), rpm, step_rpm[i]);
    end
    check("step_avg", period_avg, 2_000_000);

    repeat (4) pulse(24_999, 24_999);
    check("sat_rpm", rpm, 65_535);
    check("sat_avg", period_avg, 50_000);

    v0 = valid_cnt;
    n = 0;
    while (stalled !== 1'b1 && n < int'(STALL_T) + 500) begin
      cyc(1);
      n++;
    end
    check("stall_flag", stalled, 1);
    cyc(10);
    check("stall_rpm", rpm, 0);
    check("stall_one_valid", valid_cnt, v0 + 1);

    v0 = valid_cnt;
    pulse(49_999, 49_999);
    check("stall_cleared", stalled, 0);
    repeat (2) pulse(49_999, 49_999);
    check("refill_silent", valid_cnt, v0);
    check("refill_rpm_zero", rpm, 0);
    pulse(49_999, 49_999);
    check("refill_valid", valid_cnt, v0 + 1);
    check("refill_rpm", rpm, 60_000);

    v0 = valid_cnt;
    high_counter = 49_999;
    low_counter  = 49_999;
    SA = 1'b1;
    cyc(20);
    Reset = 1'b0;
    #1;
    check("divrst_rpm", rpm, 0);
    check("divrst_valid", rpm_valid, 0);
    check("divrst_avg", period_avg, 0);
    check("divrst_stalled", stalled, 0);
    SA = 1'b0;
    cyc(5);
    Reset = 1'b1;
    cyc(60);
    check("divrst_no_valid", valid_cnt, v0);
    repeat (3) pulse(49_999, 49_999);
    check("divrst_refill_silent", valid_cnt, v0);
    pulse(49_999, 49_999);
    check("divrst_recover_valid", valid_cnt, v0 + 1);
    check("divrst_recover_rpm", rpm, 60_000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
